mem_port_arbiter: RTL

//  Shares one unified single-ported memory between fetch (instruction) and MEM-stage (load/store) requesters.

---
 rtl/tartaruga_pkg.sv | 27 ++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga memory path: arbiter state, port owner and
// the bundled request fields presented to the unified memory.
package tartaruga_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ_PEND,
    ARB_WAIT_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } mem_owner_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Fetches are always full-word reads.
  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters, one
// outstanding transaction at a time, data-first with bounded fetch starvation.
//
//  state          | meaning
//  ---------------+-----------------------------------------------------------
//  ARB_IDLE       | no transaction; arbitrate and present winner to memory
//  ARB_REQ_PEND   | owner's request presented, waiting for mem_gnt_i
//  ARB_WAIT_RESP  | request accepted, waiting for mem_rvalid_i
module mem_port_arbiter
  import tartaruga_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  mem_owner_e    owner_q, owner_d;
  mem_owner_e    winner, sel;
  logic [CW-1:0] starve_q, starve_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;
  logic          req, if_gnt, dm_gnt, if_rv, dm_rv;
  mem_req_t      if_fields, dm_fields, mem_fields;

  assign if_fields = '{we: 1'b0, be: FETCH_BE, addr: if_addr_i, wdata: 32'h0};
  assign dm_fields = '{we: dm_we_i, be: dm_be_i, addr: dm_addr_i, wdata: dm_wdata_i};

  always_comb begin
    winner = OWN_NONE;
    if (dm_req_i && !(if_req_i && starve_q == LIMIT)) winner = OWN_DM;
    else if (if_req_i)                                winner = OWN_IF;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    sel     = OWN_NONE;
    req     = 1'b0;
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    if_rv   = 1'b0;
    dm_rv   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        sel = winner;
        if (winner != OWN_NONE) begin
          req     = 1'b1;
          owner_d = winner;
          state_d = mem_gnt_i ? ARB_WAIT_RESP : ARB_REQ_PEND;
        end
      end
      ARB_REQ_PEND: begin
        sel = owner_q;
        req = 1'b1;
        if (mem_gnt_i) state_d = ARB_WAIT_RESP;
      end
      ARB_WAIT_RESP: begin
        if (mem_rvalid_i) begin
          if_rv   = (owner_q == OWN_IF) && !drop_q && !flush_i;
          dm_rv   = (owner_q == OWN_DM);
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
    if_gnt = req && mem_gnt_i && (sel == OWN_IF);
    dm_gnt = req && mem_gnt_i && (sel == OWN_DM);
    // Drop flag lives exactly as long as the flushed fetch is in flight.
    if (state_q == ARB_WAIT_RESP && mem_rvalid_i)
      drop_d = 1'b0;
    else if (flush_i && owner_q == OWN_IF && state_q != ARB_IDLE)
      drop_d = 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt)          starve_d = '0;
    else if (dm_gnt && starve_q != LIMIT) starve_d = starve_q + CW'(1);
  end

  assign err_d = err_q | (mem_rvalid_i && state_q != ARB_WAIT_RESP);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  // Outputs are forced low while reset is held, including combinational paths.
  assign mem_fields     = req ? ((sel == OWN_DM) ? dm_fields : if_fields) : '0;
  assign mem_req_o      = rstn_i & req;
  assign mem_we_o       = rstn_i & mem_fields.we;
  assign mem_be_o       = rstn_i ? mem_fields.be    : 4'h0;
  assign mem_addr_o     = rstn_i ? mem_fields.addr  : 32'h0;
  assign mem_wdata_o    = rstn_i ? mem_fields.wdata : 32'h0;
  assign if_gnt_o       = rstn_i & if_gnt;
  assign dm_gnt_o       = rstn_i & dm_gnt;
  assign if_rvalid_o    = rstn_i & if_rv;
  assign dm_rvalid_o    = rstn_i & dm_rv;
  assign if_rdata_o     = rstn_i ? mem_rdata_i : 32'h0;
  assign dm_rdata_o     = rstn_i ? mem_rdata_i : 32'h0;
  assign busy_o         = rstn_i & (state_q != ARB_IDLE);
  assign protocol_err_o = rstn_i & err_q;

endmodule
